// File: rtl/mix_columns_seq_pkg.sv
// Shared GF(2^8) helpers, MixColumns coefficient sets and FSM state encoding
// for the AES MixColumns / InvMixColumns engine.
package mix_columns_seq_pkg;

    localparam logic [31:0] MIX_FWD = 32'h02030101;
    localparam logic [31:0] MIX_INV = 32'h0e0b0d09;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Every MixColumns coefficient fits in a nibble, so a 3-step xtime chain covers them all.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] coef);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{coef[0]}} & b) ^ ({8{coef[1]}} & x2) ^
               ({8{coef[2]}} & x4) ^ ({8{coef[3]}} & x8);
    endfunction

endpackage

// File: rtl/mix_columns_seq_unit.sv
// Combinational single-column MixColumns / InvMixColumns; row 0 is the column MSB byte.
module mix_column_unit
    import mix_columns_seq_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        inv_i,
    output logic [31:0] col_o
);

    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                col_o[31-8*r -: 8] = col_o[31-8*r -: 8] ^ gf_mul_const(
                    col_i[31-8*k -: 8],
                    inv_i ? MIX_INV[27-8*((k-r+4)%4) -: 4]
                          : MIX_FWD[27-8*((k-r+4)%4) -: 4]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns engine: transforms COLS_PER_CYCLE columns per clock in place,
// then holds the full result until the downstream stage takes it.
//
// state | meaning
// IDLE  | waiting for a state; in_ready=1
// RUN   | transforming column groups of work_q; busy=1
// DONE  | out_state valid and stable until out_ready; may accept the next state
module mix_columns_seq
    import mix_columns_seq_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);

    state_e         state_q;
    logic [1:0]     col_cnt_q;
    logic [127:0]   work_q;
    logic [127:0]   work_d;
    logic           inv_q;
    logic [127:0]   out_state_q;
    logic           out_valid_q;
    logic           busy_q;
    logic           accept;
    logic           last_grp;

    logic [1:0]     col_idx  [COLS_PER_CYCLE];
    logic [31:0]    unit_in  [COLS_PER_CYCLE];
    logic [31:0]    unit_out [COLS_PER_CYCLE];

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_unit
        assign col_idx[i] = col_cnt_q + 2'(i);
        assign unit_in[i] = work_q[127-32*col_idx[i] -: 32];
        mix_column_unit u_col (
            .col_i (unit_in[i]),
            .inv_i (inv_q),
            .col_o (unit_out[i])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            work_d[127-32*col_idx[i] -: 32] = unit_out[i];
        end
    end

    assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign last_grp  = (col_cnt_q == LAST_GRP);
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_cnt_q   <= '0;
            work_q      <= '0;
            inv_q       <= 1'b0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q    <= in_state;
                        inv_q     <= in_inverse;
                        col_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    work_q    <= work_d;
                    col_cnt_q <= col_cnt_q + COL_STEP;
                    if (last_grp) begin
                        out_state_q <= work_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            work_q    <= in_state;
                            inv_q     <= in_inverse;
                            col_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= RUN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: one instance per legal COLS_PER_CYCLE, each checked
// against a plain GF(2^8) matrix-product model.
module tb_mix_columns_seq;

    localparam int COLS_OF [3] = '{1, 2, 4};

    logic         clk = 1'b0;
    logic         rst_n      [3];
    logic         in_valid   [3];
    logic         in_ready   [3];
    logic [127:0] in_state   [3];
    logic         in_inverse [3];
    logic         out_valid  [3];
    logic         out_ready  [3];
    logic [127:0] out_state  [3];
    logic         busy       [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_state   (in_state[g]),
            .in_inverse (in_inverse[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_state  (out_state[g]),
            .busy       (busy[g])
        );
    end

    // Full polynomial product, then reduction modulo 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   a  [4];
        logic [7:0]   o;
        logic [127:0] r;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                o = '0;
                for (int k = 0; k < 4; k++) o = o ^ gmul(cf[(k - rr + 4) % 4], a[k]);
                r[127-32*c-8*rr -: 8] = o;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offers one state, waits for the result and checks acceptance and latency.
    task automatic run_txn(input int d, input logic [127:0] st, input logic inv,
                           output logic [127:0] res);
        int k;
        in_state[d] = st; in_inverse[d] = inv; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
        k = 0;
        while (!in_ready[d] && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (in_ready[d] !== 1'b1) begin
            errors++; $display("FAIL accept_timeout cols=%0d in_ready=%b want 1", COLS_OF[d], in_ready[d]);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0; in_state[d] = rand128(); in_inverse[d] = ~inv;
        checks++;
        if (busy[d] !== 1'b1) begin
            errors++; $display("FAIL busy_run cols=%0d got %b want 1", COLS_OF[d], busy[d]);
        end
        k = 0;
        while (out_valid[d] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (k !== 4 / COLS_OF[d]) begin
            errors++; $display("FAIL latency cols=%0d got %0d want %0d", COLS_OF[d], k, 4 / COLS_OF[d]);
        end
        res = out_state[d];
    endtask

    task automatic drain(input int d);
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        checks++;
        if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
            errors++; $display("FAIL drain cols=%0d out_valid=%b busy=%b want 0 0", COLS_OF[d], out_valid[d], busy[d]);
        end
    endtask

    task automatic test_reset(input int d);
        rst_n[d] = 1'b0; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
        in_state[d] = rand128(); in_inverse[d] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b0) begin
            errors++; $display("FAIL reset_flags cols=%0d ov=%b busy=%b ir=%b want 0 0 0",
                               COLS_OF[d], out_valid[d], busy[d], in_ready[d]);
        end
        checks++;
        if (out_state[d] !== 128'h0) begin
            errors++; $display("FAIL reset_out cols=%0d got %h want 0", COLS_OF[d], out_state[d]);
        end
        in_valid[d] = 1'b0; rst_n[d] = 1'b1;
        #1;
        checks++;
        if (in_ready[d] !== 1'b1) begin
            errors++; $display("FAIL reset_ready cols=%0d got %b want 1", COLS_OF[d], in_ready[d]);
        end
        @(negedge clk);
    endtask

    task automatic test_fips(input int d);
        logic [127:0] res;
        run_txn(d, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, res);
        checks++;
        if (res !== 128'h046681e5_e0cb199a_48f8d37a_2806264c) begin
            errors++; $display("FAIL fips_fwd cols=%0d got %h want 046681e5e0cb199a48f8d37a2806264c", COLS_OF[d], res);
        end
        drain(d);
        run_txn(d, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1, res);
        checks++;
        if (res !== 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5) begin
            errors++; $display("FAIL fips_inv cols=%0d got %h want d4bf5d30e0b452aeb84111f11e2798e5", COLS_OF[d], res);
        end
        drain(d);
    endtask

    task automatic test_columns(input int d);
        logic [127:0] res;
        run_txn(d, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, res);
        checks++;
        if (res !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
            errors++; $display("FAIL known_cols cols=%0d got %h want 8e4da1bc9fdc589d01010101c6c6c6c6", COLS_OF[d], res);
        end
        drain(d);
    endtask

    task automatic test_back_to_back(input int d);
        logic [127:0] a, b, res;
        int k;
        bit stable;
        a = rand128(); b = rand128();
        run_txn(d, a, 1'b0, res);
        checks++;
        if (res !== ref_mix(a, 1'b0)) begin
            errors++; $display("FAIL b2b_first cols=%0d got %h want %h", COLS_OF[d], res, ref_mix(a, 1'b0));
        end
        in_valid[d] = 1'b1; in_state[d] = b; in_inverse[d] = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid[d] !== 1'b1 || out_state[d] !== res || in_ready[d] !== 1'b0 || busy[d] !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++; $display("FAIL stall_hold cols=%0d ov=%b ir=%b out=%h want 1 0 %h",
                               COLS_OF[d], out_valid[d], in_ready[d], out_state[d], res);
        end
        out_ready[d] = 1'b1;
        #1;
        checks++;
        if (in_ready[d] !== 1'b1) begin
            errors++; $display("FAIL b2b_ready cols=%0d got %b want 1", COLS_OF[d], in_ready[d]);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0; out_ready[d] = 1'b0;
        checks++;
        if (out_valid[d] !== 1'b0 || busy[d] !== 1'b1) begin
            errors++; $display("FAIL b2b_accept cols=%0d ov=%b busy=%b want 0 1", COLS_OF[d], out_valid[d], busy[d]);
        end
        k = 0;
        while (out_valid[d] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (k !== 4 / COLS_OF[d]) begin
            errors++; $display("FAIL b2b_latency cols=%0d got %0d want %0d", COLS_OF[d], k, 4 / COLS_OF[d]);
        end
        checks++;
        if (out_state[d] !== ref_mix(b, 1'b1)) begin
            errors++; $display("FAIL b2b_second cols=%0d got %h want %h", COLS_OF[d], out_state[d], ref_mix(b, 1'b1));
        end
        drain(d);
    endtask

    task automatic test_mid_reset(input int d);
        logic [127:0] st, res;
        bit quiet;
        st = rand128();
        in_state[d] = st; in_inverse[d] = 1'b0; in_valid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0; rst_n[d] = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid[d] !== 1'b0 || out_state[d] !== 128'h0 || busy[d] !== 1'b0) begin
            errors++; $display("FAIL midreset_clear cols=%0d ov=%b busy=%b out=%h want 0 0 0",
                               COLS_OF[d], out_valid[d], busy[d], out_state[d]);
        end
        rst_n[d] = 1'b1;
        #1;
        checks++;
        if (in_ready[d] !== 1'b1) begin
            errors++; $display("FAIL midreset_ready cols=%0d got %b want 1", COLS_OF[d], in_ready[d]);
        end
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid[d] !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL midreset_stale cols=%0d out_valid=1 want 0", COLS_OF[d]);
        end
        st = rand128();
        run_txn(d, st, 1'b1, res);
        checks++;
        if (res !== ref_mix(st, 1'b1)) begin
            errors++; $display("FAIL midreset_next cols=%0d got %h want %h", COLS_OF[d], res, ref_mix(st, 1'b1));
        end
        drain(d);
    endtask

    task automatic test_random(input int d);
        logic [127:0] st, res, back;
        logic inv;
        int stall;
        bit stable;
        for (int n = 0; n < 500; n++) begin
            st = rand128(); inv = 1'($urandom_range(0, 1));
            run_txn(d, st, inv, res);
            checks++;
            if (res !== ref_mix(st, inv)) begin
                errors++; $display("FAIL rand_model cols=%0d n=%0d got %h want %h", COLS_OF[d], n, res, ref_mix(st, inv));
            end
            stall = $urandom_range(0, 3);
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (out_valid[d] !== 1'b1 || out_state[d] !== res) stable = 1'b0;
            end
            checks++;
            if (!stable) begin
                errors++; $display("FAIL rand_stall cols=%0d n=%0d out=%h want %h", COLS_OF[d], n, out_state[d], res);
            end
            drain(d);
            run_txn(d, res, ~inv, back);
            checks++;
            if (back !== st) begin
                errors++; $display("FAIL rand_roundtrip cols=%0d n=%0d got %h want %h", COLS_OF[d], n, back, st);
            end
            drain(d);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; in_valid[d] = 1'b0; in_state[d] = '0;
            in_inverse[d] = 1'b0; out_ready[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            test_reset(d);
            test_fips(d);
            test_columns(d);
            test_back_to_back(d);
            test_mid_reset(d);
            test_random(d);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
